// File: rtl/ixu_binfo_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : ixu_binfo_alloc
//  Purpose  : Allocator / sequencer for the branch-info pack store of the
//             integer execution unit. Slots form a circular buffer:
//             head = allocate pointer, tail = free pointer. Pointers are
//             PACK_W+1 bits wide; the MSB is the wrap bit that separates
//             full from empty.
//
//  Ports    :
//    core_clock_i     in   1         core clock, rising edge
//    core_reset_i     in   1         asynchronous, active-high reset
//    alloc_req_i      in   1         rename requests one pack slot
//    alloc_gnt_o      out  1         request granted this cycle (comb.)
//    alloc_pack_o     out  PACK_W    granted pack ID
//    binfo_wen_o      out  1         branch-info store write enable
//    binfo_pack_o     out  PACK_W    branch-info store write index
//    free_i           in   1         commit retires the oldest slot
//    oldest_pack_o    out  PACK_W    pack ID of the oldest live slot
//    flush_i          in   1         discard all uncommitted slots
//    rollback_i       in   1         discard slots younger than rollback_pack_i
//    rollback_pack_i  in   PACK_W    mispredicting pack (kept)
//    count_o          out  PACK_W+1  slots in use
//    full_o           out  1         all slots in use
//    empty_o          out  1         no slot in use
//    err_o            out  1         one-cycle pulse on illegal free/rollback
//
//  Revision : 1.0  initial release
// ============================================================================
module ixu_binfo_alloc #(
    parameter int PACK_W = 4
) (
    input  logic              core_clock_i,
    input  logic              core_reset_i,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [PACK_W-1:0] alloc_pack_o,
    output logic              binfo_wen_o,
    output logic [PACK_W-1:0] binfo_pack_o,
    input  logic              free_i,
    output logic [PACK_W-1:0] oldest_pack_o,
    input  logic              flush_i,
    input  logic              rollback_i,
    input  logic [PACK_W-1:0] rollback_pack_i,
    output logic [PACK_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    localparam int             c_DEPTH     = 2 ** PACK_W;
    localparam logic [PACK_W:0] c_DEPTH_CNT = c_DEPTH[PACK_W:0];
    localparam logic [PACK_W:0] c_PTR_ONE   = {{PACK_W{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PACK_W:0] r_head;
    logic [PACK_W:0] r_tail;
    logic            r_err;

    // ------------------------------------------------------------------
    // Occupancy decode
    // ------------------------------------------------------------------
    logic [PACK_W:0] w_count;
    logic            w_full;
    logic            w_empty;

    // Modular subtraction over the extended pointer space yields 0..DEPTH.
    assign w_count = r_head - r_tail;
    assign w_full  = (w_count == c_DEPTH_CNT);
    assign w_empty = (w_count == '0);

    // ------------------------------------------------------------------
    // Grant: flush and rollback both suppress allocation; reset also
    // suppresses it so no store write can escape while reset is held.
    // ------------------------------------------------------------------
    logic w_gnt;

    assign w_gnt = alloc_req_i & ~w_full & ~flush_i & ~rollback_i & ~core_reset_i;

    // ------------------------------------------------------------------
    // Free: applied regardless of flush/rollback/alloc, unless empty.
    // ------------------------------------------------------------------
    logic            w_free_ok;
    logic            w_free_err;
    logic [PACK_W:0] w_tail_next;

    assign w_free_ok   = free_i & ~w_empty;
    assign w_free_err  = free_i &  w_empty;
    assign w_tail_next = r_tail + {{PACK_W{1'b0}}, w_free_ok};

    // ------------------------------------------------------------------
    // Rollback: distance of the mispredicting pack from the oldest slot.
    // The pack is live only if that distance is below the current count;
    // the new head sits just past it, measured from the pre-free tail so a
    // concurrent free simply shrinks the surviving window by one.
    // ------------------------------------------------------------------
    logic [PACK_W-1:0] w_rb_off;
    logic              w_rb_hit;
    logic              w_rb_err;
    logic [PACK_W:0]   w_rb_head;

    assign w_rb_off  = rollback_pack_i - r_tail[PACK_W-1:0];
    assign w_rb_hit  = ({1'b0, w_rb_off} < w_count);
    assign w_rb_err  = rollback_i & ~flush_i & ~w_rb_hit;
    assign w_rb_head = r_tail + {1'b0, w_rb_off} + c_PTR_ONE;

    // ------------------------------------------------------------------
    // Head update: flush > rollback > alloc
    // ------------------------------------------------------------------
    logic [PACK_W:0] w_head_next;

    always_comb begin
        w_head_next = r_head;
        if (flush_i) begin
            // Tracks the post-free tail so the buffer reads empty next cycle.
            w_head_next = w_tail_next;
        end else if (rollback_i) begin
            if (w_rb_hit) begin
                w_head_next = w_rb_head;
            end
        end else if (w_gnt) begin
            w_head_next = r_head + c_PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_err  <= 1'b0;
        end else begin
            r_head <= w_head_next;
            r_tail <= w_tail_next;
            r_err  <= w_free_err | w_rb_err;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alloc_gnt_o   = w_gnt;
    assign alloc_pack_o  = r_head[PACK_W-1:0];
    assign binfo_wen_o   = w_gnt;
    assign binfo_pack_o  = r_head[PACK_W-1:0];
    assign oldest_pack_o = r_tail[PACK_W-1:0];
    assign count_o       = w_count;
    assign full_o        = w_full;
    assign empty_o       = w_empty;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ixu_binfo_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ixu_binfo_alloc
//  Purpose  : Self-checking bench for ixu_binfo_alloc. A behavioural
//             occupancy model produces the expected outputs for each driven
//             cycle; they are queued when the stimulus is applied and popped
//             when the DUT outputs are sampled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ixu_binfo_alloc;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [3:0] alloc_pack;
    logic       binfo_wen;
    logic [3:0] binfo_pack;
    logic       free_r;
    logic [3:0] oldest_pack;
    logic       flush;
    logic       rollback;
    logic [3:0] rollback_pack;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic       gnt;
        logic [3:0] pack;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic [3:0] oldest;
        logic       err;
    } exp_t;

    exp_t sb[$];

    // Reference model state: plain integers, 0..31
    int   m_head;
    int   m_tail;
    logic m_err;

    ixu_binfo_alloc #(.PACK_W(4)) dut (
        .core_clock_i    (clk),
        .core_reset_i    (rst),
        .alloc_req_i     (alloc_req),
        .alloc_gnt_o     (alloc_gnt),
        .alloc_pack_o    (alloc_pack),
        .binfo_wen_o     (binfo_wen),
        .binfo_pack_o    (binfo_pack),
        .free_i          (free_r),
        .oldest_pack_o   (oldest_pack),
        .flush_i         (flush),
        .rollback_i      (rollback),
        .rollback_pack_i (rollback_pack),
        .count_o         (count),
        .full_o          (full),
        .empty_o         (empty),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int m_count();
        return (m_head - m_tail) & 31;
    endfunction

    task automatic model_reset();
        m_head = 0;
        m_tail = 0;
        m_err  = 1'b0;
    endtask

    // One clock of stimulus. Called 1 time unit after a rising edge;
    // returns 1 time unit after the next rising edge.
    task automatic step(input logic req, input logic fr, input logic fl,
                        input logic rb, input logic [3:0] rp, input string tag);
        exp_t e;
        exp_t o;
        int   c;
        int   off;
        int   nt;
        int   nh;
        logic ne;
        alloc_req     = req;
        free_r        = fr;
        flush         = fl;
        rollback      = rb;
        rollback_pack = rp;

        c        = m_count();
        e.tag    = tag;
        e.cnt    = 5'(c);
        e.full   = (c == 16);
        e.empty  = (c == 0);
        e.gnt    = req && (c != 16) && !fl && !rb;
        e.pack   = 4'(m_head & 15);
        e.oldest = 4'(m_tail & 15);
        e.err    = m_err;
        sb.push_back(e);

        #3;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            chk({o.tag, "_gnt"},    {31'd0, alloc_gnt},   {31'd0, o.gnt});
            chk({o.tag, "_wen"},    {31'd0, binfo_wen},   {31'd0, o.gnt});
            if (o.gnt) begin
                chk({o.tag, "_pack"},  {28'd0, alloc_pack}, {28'd0, o.pack});
                chk({o.tag, "_wpack"}, {28'd0, binfo_pack}, {28'd0, o.pack});
            end
            chk({o.tag, "_count"},  {27'd0, count},       {27'd0, o.cnt});
            chk({o.tag, "_full"},   {31'd0, full},        {31'd0, o.full});
            chk({o.tag, "_empty"},  {31'd0, empty},       {31'd0, o.empty});
            chk({o.tag, "_oldest"}, {28'd0, oldest_pack}, {28'd0, o.oldest});
            chk({o.tag, "_err"},    {31'd0, err},         {31'd0, o.err});
        end

        // Model update for the coming edge
        nt = (fr && c != 0) ? ((m_tail + 1) & 31) : m_tail;
        ne = fr && (c == 0);
        nh = m_head;
        if (fl) begin
            nh = nt;
        end else if (rb) begin
            off = (int'(rp) - m_tail) & 15;
            if (off < c) nh = (m_tail + off + 1) & 31;
            else         ne = 1'b1;
        end else if (e.gnt) begin
            nh = (m_head + 1) & 31;
        end

        @(posedge clk);
        m_head = nh;
        m_tail = nt;
        m_err  = ne;
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req     = 1'b0;
        free_r        = 1'b0;
        flush         = 1'b0;
        rollback      = 1'b0;
        rollback_pack = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        alloc_req = 1'b1;  // request during reset must not be granted
        model_reset();
        #2;
        chk("rst_gnt",    {31'd0, alloc_gnt},   32'd0);
        chk("rst_wen",    {31'd0, binfo_wen},   32'd0);
        chk("rst_count",  {27'd0, count},       32'd0);
        chk("rst_empty",  {31'd0, empty},       32'd1);
        chk("rst_full",   {31'd0, full},        32'd0);
        chk("rst_oldest", {28'd0, oldest_pack}, 32'd0);
        chk("rst_err",    {31'd0, err},         32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();

        // Fill: 16 grants then a denied request
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "fill");
        chk("fill_count", {27'd0, count}, 32'd16);
        chk("fill_full",  {31'd0, full},  32'd1);

        // Full with free + alloc: alloc denied, then wrap to pack 0
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "full_free");
        chk("ff_count",  {27'd0, count},       32'd15);
        chk("ff_oldest", {28'd0, oldest_pack}, 32'd1);
        alloc_req = 1'b1;
        #1;
        chk("wrap_pack", {28'd0, alloc_pack}, 32'd0);
        #0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "wrap");
        chk("wrap_count", {27'd0, count}, 32'd16);

        // Rollback to pack 2 after packs 0..5
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "rb_fill");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, "rb2");
        chk("rb_count", {27'd0, count}, 32'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "rb_next");
        chk("rb_next_count", {27'd0, count}, 32'd4);

        // Rollback to an unallocated pack
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "bad_fill");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, "rb9");
        chk("rb9_count", {27'd0, count}, 32'd4);
        chk("rb9_err",   {31'd0, err},   32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "rb9_after");
        chk("rb9_err_clr", {31'd0, err}, 32'd0);

        // Flush with concurrent alloc and free
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "fl_fill");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "flush");
        chk("fl_count",  {27'd0, count},       32'd0);
        chk("fl_empty",  {31'd0, empty},       32'd1);
        chk("fl_oldest", {28'd0, oldest_pack}, 32'd1);

        // Free while empty
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "free_empty");
        chk("fe_err",   {31'd0, err},   32'd1);
        chk("fe_count", {27'd0, count}, 32'd0);

        // Reset in the middle of an allocation burst
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "burst");
        alloc_req = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_gnt",    {31'd0, alloc_gnt},   32'd0);
        chk("mid_wen",    {31'd0, binfo_wen},   32'd0);
        chk("mid_count",  {27'd0, count},       32'd0);
        chk("mid_empty",  {31'd0, empty},       32'd1);
        chk("mid_oldest", {28'd0, oldest_pack}, 32'd0);
        chk("mid_err",    {31'd0, err},         32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        model_reset();

        // Random traffic against the model (wrap, rollback + free, etc.)
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 8),
                 4'($urandom_range(0, 15)),
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ixu_binfo_alloc.md
Name: ixu_binfo_alloc

Overview:
Allocator and sequencer for the 16-entry branch-info pack store in the integer execution unit.
- Rename requests a pack slot for each branch-carrying packet. The block grants a pack ID and drives the write-enable and pack index of the branch-info store.
- Commit frees slots in order, oldest first.
- A full flush or a partial rollback after a mispredict reclaims speculative slots.
- Slots form a circular buffer: head is the allocate pointer, tail is the free pointer.

Parameters:
PACK_W, 4, pack index width. Depth is 2**PACK_W = 16 slots. Pointers are PACK_W+1 bits, with the MSB as the wrap bit.

Ports:
core_clock_i  in  1  core clock, rising edge
core_reset_i  in  1  asynchronous, active-high reset
alloc_req_i  in  1  rename requests one pack slot this cycle
alloc_gnt_o  out  1  request granted this cycle (combinational)
alloc_pack_o  out  PACK_W  granted pack ID (head[3:0])
binfo_wen_o  out  1  write enable to the branch-info store (equals alloc_gnt_o)
binfo_pack_o  out  PACK_W  write index to the branch-info store (equals alloc_pack_o)
free_i  in  1  commit retires the oldest slot
oldest_pack_o  out  PACK_W  tail[3:0]; read index used by the commit/branch-resolve side
flush_i  in  1  full pipeline flush; discard all uncommitted slots
rollback_i  in  1  mispredict; discard all slots younger than rollback_pack_i
rollback_pack_i  in  PACK_W  pack ID of the mispredicting branch; this slot is kept
count_o  out  PACK_W+1  slots in use, 0..16
full_o  out  1  count_o == 16
empty_o  out  1  count_o == 0
err_o  out  1  one-cycle registered pulse on an illegal free or rollback

Behaviour:
- Reset (asynchronous, core_reset_i high):
  - head = tail = 0, err_o = 0.
  - Outputs: count_o = 0, empty_o = 1, full_o = 0, oldest_pack_o = 0.
  - alloc_gnt_o and binfo_wen_o are forced to 0 while reset is asserted.
- Derived signals: count = head - tail, modulo 32. full and empty are decoded from count.
- Grant logic:
  - alloc_gnt_o = alloc_req_i & ~full_o & ~flush_i & ~rollback_i.
  - The grant is combinational, in the same cycle as the request.
  - On grant, head increments at the next edge and the packet's RAM write happens that same edge.
  - At most one allocation per cycle.
- Free:
  - If free_i and not empty, tail increments at the next edge.
  - If free_i while empty, the free is ignored and err_o pulses the next cycle.
  - A free is processed in the same cycle as a grant, flush or rollback.
- Flush (flush_i, highest priority):
  - head_next = tail_next, where tail_next already includes any concurrent free.
  - Result: count = 0 the next cycle.
  - Any rollback or alloc in the same cycle is ignored.
- Rollback (rollback_i and not flush_i):
  - off = (rollback_pack_i - tail[3:0]) mod 16.
  - If off < count: head_next = tail + off + 1. The slot is kept; all younger slots are freed.
  - If off >= count (slot not allocated): head is unchanged and err_o pulses.
  - If a free happens concurrently: tail_next = tail + 1 and the resulting count = off.
- Priority: flush > rollback > alloc. Free is always applied (subject to the empty check).
- Wrap-around: pointers wrap naturally at 32. The pack ID is the low 4 bits. Full is distinguished from empty by the wrap bit.
- All pointer updates are synchronous on the rising edge of core_clock_i.
- Reset asserted mid-operation returns all state to the reset values immediately. No RAM write occurs while reset is asserted.

Test Plan:
- Reset, then alloc_req_i held high for 17 cycles -> grants on the first 16 with packs 0..15, binfo_wen_o high on each; cycle 17: gnt = 0, full_o = 1, count_o = 16.
- Full buffer plus free_i and alloc_req_i in the same cycle -> alloc denied that cycle (full_o still 1); next cycle count = 15, oldest_pack_o = 1, and alloc then grants pack 0 (wrap), count = 16.
- Allocate packs 0..5, then rollback_i with pack 2 -> next cycle count_o = 3; next grant returns pack 3.
- Allocate packs 0..3, then rollback_i with pack 9 -> head unchanged, count_o = 4, err_o pulses one cycle.
- Allocate 4, then flush_i with alloc_req_i and free_i in the same cycle -> gnt = 0, count_o = 0, empty_o = 1, tail = head = 1.
- free_i while empty -> count stays 0, err_o pulses. Then assert core_reset_i mid-allocation burst -> all outputs return to reset values immediately.
